ci_sequencer: RTL
=================

# ci_sequencer

Sequencer between the CPU custom-instruction port and up to NUM_UNITS multi-cycle custom-instruction units, such as profileCi. It decodes ciN and registers the operands. It then issues a one-cycle start to the selected unit, waits for that unit's done, and returns its result to the CPU with a one-cycle done pulse. Unknown IDs and hung units are also resolved so that the CPU never stalls forever.

## Interface
- NUM_UNITS, 4: number of attached units, 1..8.
- ID_BASE, 8'h00: unit i answers to ciN == ID_BASE + i.
- TIMEOUT, 1023: maximum cycles spent waiting for a unit done.
- clock  in  1  system clock; all state is on the rising edge.
- reset  in  1  one clock; reset is asynchronous and active-low.
- ciStart  in  1  CPU request, sampled only in IDLE.
- ciN  in  8  custom-instruction ID.
- ciValueA  in  32  operand A.
- ciValueB  in  32  operand B.
- ciDone  out  1  one-cycle completion pulse.
- ciResult  out  32  result; valid only while ciDone = 1, otherwise 0.
- unitStart  out  NUM_UNITS  one-hot, one-cycle start to the selected unit.
- unitValueA  out  32  registered operand A, held from the start cycle until completion.
- unitValueB  out  32  registered operand B, held from the start cycle until completion.
- unitDone  in  NUM_UNITS  per-unit done.
- unitResult  in  32*NUM_UNITS  per-unit result; unit i occupies bits [32i+31:32i].
- busy  out  1  high in every state except IDLE.
- errUnknown  out  1  sticky; set by an unknown ID, cleared only by reset.
- errTimeout  out  1  sticky; set by a timeout, cleared only by reset.

## Operation
- States:
  - IDLE: waits for a request.
  - ISSUE: drives the unit start.
  - WAIT: waits for the unit done.
  - RESP: returns the response.
- IDLE, ciStart = 1:
  - Latch ciN, ciValueA and ciValueB.
  - Compute sel = ciN - ID_BASE using 8-bit unsigned arithmetic.
  - If sel < NUM_UNITS, go to ISSUE.
  - Otherwise set errUnknown, load the response register with 32'h0 and go to RESP.
- ISSUE:
  - unitStart[sel] = 1 for exactly this cycle.
  - Clear the timeout counter and go to WAIT.
  - If unitDone[sel] is already 1 in this cycle (combinational unit), capture unitResult[sel] and go directly to RESP.
- WAIT:
  - If unitDone[sel] = 1, capture unitResult[sel] and go to RESP.
  - Otherwise increment the 10-bit counter, sized to hold TIMEOUT.
  - When the counter reaches TIMEOUT, set errTimeout, load the response register with 32'hFFFF_FFFF and go to RESP.
- RESP: ciDone = 1 and ciResult = response register for one cycle, then return to IDLE.
- unitDone from a non-selected unit, or in IDLE/RESP, is ignored.
- ciStart outside IDLE is ignored; no queueing.
- A unit done that coincides with the timeout terminal count takes priority: the real result is returned and errTimeout is not set.
- Operand bus registers update only on an IDLE accept. ciN wrap is not special-cased: ID_BASE = 8'hFE with ciN = 8'h01 gives sel = 3.

## Timing
- Reset values:
  - State is IDLE.
  - ciDone, unitStart, busy, errUnknown and errTimeout are all 0.
  - ciResult, unitValueA, unitValueB and all internal registers are 0.
- Label the accept edge as cycle 0. Then:
  - unitStart is high in cycle 1.
  - A done in cycle 1 gives ciDone in cycle 2, which is the minimum latency.
  - A done in cycle k gives ciDone in cycle k+1.
  - An unknown ID gives ciDone in cycle 1.
  - A timeout gives ciDone in cycle TIMEOUT+2.
- A new request can be accepted in the cycle after ciDone, so the back-to-back period is 3 cycles minimum.
- Reset asserted mid-operation returns the block to IDLE immediately. No ciDone is produced for the aborted request, and no further unitStart is produced.

## Structure
- Shared package ci_pkg holds:
  - the state encoding enum;
  - the constants CI_ERR_RESULT = 32'hFFFF_FFFF and CI_UNKNOWN_RESULT = 32'h0;
  - CI_DATA_W = 32 and CI_ID_W = 8.
- One sub-module, ci_timeout_counter, provides clear, enable and terminal-count outputs. Everything else is flat.

## Test plan
- Unit 2 done 3 cycles after its start:
  - stimulus: ciN = 8'h02, A = 5, B = 8'hF;
  - required: unitStart = 4'b0100 for 1 cycle, unitValueA = 5;
  - required: ciDone 1 cycle after the unit done, with ciResult = unitResult[2];
  - required: busy falls in the same cycle ciDone falls.
- Combinational unit 0 (unitDone[0] tied high):
  - stimulus: ciN = 8'h00;
  - required: ciDone in cycle 2 with the result; no extra unitStart.
- Unknown ID:
  - stimulus: ciN = 8'h07, NUM_UNITS = 4;
  - required: ciDone in cycle 1, ciResult = 0, errUnknown = 1, no unitStart;
  - required: the following valid request still completes normally.
- Hung unit:
  - stimulus: TIMEOUT = 15, unit 1 never completes;
  - required: ciDone in cycle 17, ciResult = 32'hFFFF_FFFF, errTimeout = 1.
- Filtering:
  - stimulus: spurious unitDone[3] while waiting on unit 1, plus ciStart pulses while busy;
  - required: both are ignored; unit 1's result is returned.
- Reset abort:
  - stimulus: reset low for 1 cycle while in WAIT;
  - required: all outputs return to 0 asynchronously and no ciDone is produced;
  - required: the next request has the normal latency.

Source files
------------

// File: rtl/ci_pkg.sv
// Shared types and constants for the custom-instruction sequencer.
package ci_pkg;

    localparam int unsigned CI_DATA_W = 32;
    localparam int unsigned CI_ID_W   = 8;
    localparam int unsigned CI_CNT_W  = 10;
    localparam int unsigned CI_SEL_W  = 3;

    localparam logic [CI_DATA_W-1:0] CI_ERR_RESULT     = 32'hFFFF_FFFF;
    localparam logic [CI_DATA_W-1:0] CI_UNKNOWN_RESULT = 32'h0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } ci_state_e;

    typedef struct packed {
        logic [CI_DATA_W-1:0] value_a;
        logic [CI_DATA_W-1:0] value_b;
    } ci_operands_t;

    // Unit index from an instruction ID; wraps modulo 256 by design.
    function automatic logic [CI_ID_W-1:0] ci_sel(input logic [CI_ID_W-1:0] id,
                                                  input logic [CI_ID_W-1:0] base);
        return id - base;
    endfunction

endpackage

// File: rtl/ci_sequencer_if.sv
// CPU-side and unit-side signals of the custom-instruction sequencer.
interface ci_sequencer_if #(
    parameter int unsigned NUM_UNITS = 4
);
    import ci_pkg::*;

    logic                           ciStart;
    logic [CI_ID_W-1:0]             ciN;
    logic [CI_DATA_W-1:0]           ciValueA;
    logic [CI_DATA_W-1:0]           ciValueB;
    logic                           ciDone;
    logic [CI_DATA_W-1:0]           ciResult;
    logic [NUM_UNITS-1:0]           unitStart;
    logic [CI_DATA_W-1:0]           unitValueA;
    logic [CI_DATA_W-1:0]           unitValueB;
    logic [NUM_UNITS-1:0]           unitDone;
    logic [CI_DATA_W*NUM_UNITS-1:0] unitResult;
    logic                           busy;
    logic                           errUnknown;
    logic                           errTimeout;

    // Sequencer side.
    modport slave (
        input  ciStart, ciN, ciValueA, ciValueB, unitDone, unitResult,
        output ciDone, ciResult, unitStart, unitValueA, unitValueB,
               busy, errUnknown, errTimeout
    );

    // Environment side: CPU plus attached units.
    modport master (
        output ciStart, ciN, ciValueA, ciValueB, unitDone, unitResult,
        input  ciDone, ciResult, unitStart, unitValueA, unitValueB,
               busy, errUnknown, errTimeout
    );

endinterface

// File: rtl/ci_timeout_counter.sv
// Wait-cycle counter; terminal count flags the last permitted wait cycle.
module ci_timeout_counter
    import ci_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic clock,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_tc_c
);

    logic [CI_CNT_W-1:0] r_count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + CI_CNT_W'(1);
        end
    end

    // The increment on this cycle would reach TIMEOUT.
    assign o_tc_c = (r_count == CI_CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/ci_sequencer.sv
// Issues CPU custom instructions to one of NUM_UNITS multi-cycle units and returns the result.
module ci_sequencer
    import ci_pkg::*;
#(
    parameter int unsigned        NUM_UNITS = 4,
    parameter logic [CI_ID_W-1:0] ID_BASE   = 8'h00,
    parameter int unsigned        TIMEOUT   = 1023
) (
    input  logic           clock,
    input  logic           reset,
    ci_sequencer_if.slave  bus
);

    ci_state_e              r_state, w_state_next;
    logic [CI_SEL_W-1:0]    r_sel, w_sel_next;
    ci_operands_t           r_ops, w_ops_next;
    logic                   r_ci_done, w_ci_done_next;
    logic [CI_DATA_W-1:0]   r_ci_result, w_ci_result_next;
    logic [NUM_UNITS-1:0]   r_unit_start, w_unit_start_next;
    logic                   r_busy, w_busy_next;
    logic                   r_err_unknown, w_err_unknown_next;
    logic                   r_err_timeout, w_err_timeout_next;

    logic [CI_ID_W-1:0]     w_sel_full;
    logic                   w_sel_valid;
    logic [NUM_UNITS-1:0]   w_sel_onehot;
    logic                   w_unit_done;
    logic [CI_DATA_W-1:0]   w_unit_result;
    logic                   w_cnt_clear;
    logic                   w_cnt_enable;
    logic                   w_tc;

    assign w_sel_full  = ci_sel(bus.ciN, ID_BASE);
    assign w_sel_valid = (w_sel_full < CI_ID_W'(NUM_UNITS));

    // Decode and per-unit muxing without out-of-range part selects.
    always_comb begin
        w_sel_onehot  = '0;
        w_unit_done   = 1'b0;
        w_unit_result = '0;
        for (int unsigned i = 0; i < NUM_UNITS; i++) begin
            w_sel_onehot[i] = (w_sel_full == CI_ID_W'(i));
            if (r_sel == CI_SEL_W'(i)) begin
                w_unit_done   = bus.unitDone[i];
                w_unit_result = bus.unitResult[CI_DATA_W*i +: CI_DATA_W];
            end
        end
    end

    ci_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clock    (clock),
        .reset    (reset),
        .i_clear  (w_cnt_clear),
        .i_enable (w_cnt_enable),
        .o_tc_c   (w_tc)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_sel         <= '0;
            r_ops         <= '0;
            r_ci_done     <= 1'b0;
            r_ci_result   <= '0;
            r_unit_start  <= '0;
            r_busy        <= 1'b0;
            r_err_unknown <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_sel         <= w_sel_next;
            r_ops         <= w_ops_next;
            r_ci_done     <= w_ci_done_next;
            r_ci_result   <= w_ci_result_next;
            r_unit_start  <= w_unit_start_next;
            r_busy        <= w_busy_next;
            r_err_unknown <= w_err_unknown_next;
            r_err_timeout <= w_err_timeout_next;
        end
    end

    // Outputs are registered from the next state so they align with the state they describe.
    always_comb begin
        w_state_next       = r_state;
        w_sel_next         = r_sel;
        w_ops_next         = r_ops;
        w_ci_done_next     = 1'b0;
        w_ci_result_next   = '0;
        w_unit_start_next  = '0;
        w_err_unknown_next = r_err_unknown;
        w_err_timeout_next = r_err_timeout;
        w_cnt_clear        = 1'b0;
        w_cnt_enable       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (bus.ciStart) begin
                    w_ops_next = '{value_a: bus.ciValueA, value_b: bus.ciValueB};
                    if (w_sel_valid) begin
                        w_sel_next        = CI_SEL_W'(w_sel_full);
                        w_unit_start_next = w_sel_onehot;
                        w_state_next      = ST_ISSUE;
                    end else begin
                        w_err_unknown_next = 1'b1;
                        w_ci_done_next     = 1'b1;
                        w_ci_result_next   = CI_UNKNOWN_RESULT;
                        w_state_next       = ST_RESP;
                    end
                end
            end
            ST_ISSUE: begin
                w_cnt_clear = 1'b1;
                if (w_unit_done) begin
                    w_ci_done_next   = 1'b1;
                    w_ci_result_next = w_unit_result;
                    w_state_next     = ST_RESP;
                end else begin
                    w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A done on the terminal-count cycle wins over the timeout.
                if (w_unit_done) begin
                    w_ci_done_next   = 1'b1;
                    w_ci_result_next = w_unit_result;
                    w_state_next     = ST_RESP;
                end else if (w_tc) begin
                    w_err_timeout_next = 1'b1;
                    w_ci_done_next     = 1'b1;
                    w_ci_result_next   = CI_ERR_RESULT;
                    w_state_next       = ST_RESP;
                end else begin
                    w_cnt_enable = 1'b1;
                end
            end
            ST_RESP: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        w_busy_next = (w_state_next != ST_IDLE);
    end

    assign bus.ciDone     = r_ci_done;
    assign bus.ciResult   = r_ci_result;
    assign bus.unitStart  = r_unit_start;
    assign bus.unitValueA = r_ops.value_a;
    assign bus.unitValueB = r_ops.value_b;
    assign bus.busy       = r_busy;
    assign bus.errUnknown = r_err_unknown;
    assign bus.errTimeout = r_err_timeout;

endmodule
